game_timer_ctrl: RTL and testbench

//  Round controller directly upstream of the two-digit down-counter chain (ones, tens) of the game timer.

---
 rtl/game_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/game_timer_ctrl.sv | 102 ++++++++++
 tb/tb_game_timer_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game timer round controller.
// The state encoding is fixed because other blocks decode the 3-bit value.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    localparam int DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV counter that divides inter_clk into single-cycle count ticks.
// It holds its count while disabled, so a paused round keeps its partial tick.
module tick_prescaler
    import game_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic inter_clk,
    input  logic clr,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count_r;

    // Count register: cleared on load, advances and wraps only while enabled.
    always_ff @(posedge inter_clk or posedge clr) begin
        if (clr) begin
            count_r <= '0;
        end else if (sync_clr) begin
            count_r <= '0;
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = en & (count_r == LAST);

endmodule

// File: rtl/game_timer_ctrl.sv
// Round controller for the two-digit down-counter chain: sequences load/run/pause/expire
// and issues the per-digit decrement enables with ripple borrow from ones to tens.
module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic inter_clk,
    input  logic clr,
    input  logic start,
    input  logic pause,
    input  logic tc_ones,
    input  logic tc_tens,
    output logic ld,
    output logic cnt_ones,
    output logic cnt_tens,
    output logic running,
    output logic expired,
    output logic expire_pulse
);

    state_t state_r;
    state_t state_s;
    logic   tick_s;
    logic   psc_en_s;
    logic   psc_clr_s;
    logic   both_tc_s;
    logic   expire_pulse_r;

    assign both_tc_s = tc_ones & tc_tens;
    // start and pause both stall the prescaler so a restart never counts a stray tick.
    assign psc_en_s  = (state_r == ST_RUN) & ~pause & ~start;
    assign psc_clr_s = (state_r == ST_LOAD);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .inter_clk (inter_clk),
        .clr       (clr),
        .en        (psc_en_s),
        .sync_clr  (psc_clr_s),
        .tick      (tick_s)
    );

    // State register.
    always_ff @(posedge inter_clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; priority is start > pause > expiry.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (start)                  state_s = ST_LOAD;
                else if (pause)             state_s = ST_PAUSED;
                else if (tick_s & both_tc_s) state_s = ST_EXPIRED;
                else                        state_s = ST_RUN;
            end
            ST_PAUSED: begin
                if (start)       state_s = ST_LOAD;
                else if (!pause) state_s = ST_RUN;
                else             state_s = ST_PAUSED;
            end
            ST_EXPIRED: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_EXPIRED;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Expiry pulse: set only on the transition into EXPIRED.
    always_ff @(posedge inter_clk or posedge clr) begin
        if (clr) begin
            expire_pulse_r <= 1'b0;
        end else begin
            expire_pulse_r <= (state_s == ST_EXPIRED) && (state_r != ST_EXPIRED);
        end
    end

    assign ld           = (state_r == ST_LOAD);
    assign running      = (state_r == ST_RUN) | (state_r == ST_PAUSED);
    assign expired      = (state_r == ST_EXPIRED);
    assign expire_pulse = expire_pulse_r;
    assign cnt_ones     = tick_s & ~both_tc_s;
    assign cnt_tens     = tick_s & tc_ones & ~tc_tens;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl with TICK_DIV=4 and a modelled two-digit counter chain.
module tb_game_timer_ctrl;

    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSED = 3, M_EXP = 4;
    localparam int DIV = 4;

    logic inter_clk = 1'b0;
    logic clr, start, pause, tc_ones, tc_tens;
    logic ld, cnt_ones, cnt_tens, running, expired, expire_pulse;

    int m_st, m_prev, m_psc;
    int ones, tens, pre_ones, pre_tens;
    int n_cmp, n_err, cyc;
    logic [5:0] obs;
    logic [5:0] sb_q[$];
    logic [5:0] log_v[0:16];

    game_timer_ctrl #(.TICK_DIV(DIV)) dut (
        .inter_clk    (inter_clk),
        .clr          (clr),
        .start        (start),
        .pause        (pause),
        .tc_ones      (tc_ones),
        .tc_tens      (tc_tens),
        .ld           (ld),
        .cnt_ones     (cnt_ones),
        .cnt_tens     (cnt_tens),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse)
    );

    always #5 inter_clk = ~inter_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE;
        m_prev = M_IDLE;
        m_psc = 0;
    endtask

    function automatic logic m_tick();
        return (m_st == M_RUN) && (m_psc == DIV - 1) && !pause && !start;
    endfunction

    // Expected {ld, cnt_ones, cnt_tens, running, expired, expire_pulse}.
    function automatic logic [5:0] model_out();
        logic t, zero;
        t = m_tick();
        zero = (ones == 0) && (tens == 0);
        return {m_st == M_LOAD, t && !zero, t && ones == 0 && tens != 0,
                m_st == M_RUN || m_st == M_PAUSED, m_st == M_EXP,
                m_st == M_EXP && m_prev != M_EXP};
    endfunction

    task automatic model_advance(input logic [5:0] e);
        int nxt;
        logic t;
        if (clr) begin
            model_reset();
            return;
        end
        t = m_tick();
        nxt = m_st;
        case (m_st)
            M_IDLE:   if (start) nxt = M_LOAD;
            M_LOAD:   nxt = M_RUN;
            M_RUN:    if (start) nxt = M_LOAD; else if (pause) nxt = M_PAUSED;
                      else if (t && ones == 0 && tens == 0) nxt = M_EXP;
            M_PAUSED: if (start) nxt = M_LOAD; else if (!pause) nxt = M_RUN;
            M_EXP:    if (start) nxt = M_LOAD;
            default:  nxt = M_IDLE;
        endcase
        if (m_st == M_LOAD) m_psc = 0;
        else if (m_st == M_RUN && !pause && !start) m_psc = (m_psc + 1) % DIV;
        m_prev = m_st;
        m_st = nxt;
        if (e[5]) begin ones = pre_ones; tens = pre_tens; end
        if (e[4]) ones = (ones == 0) ? 9 : ones - 1;
        if (e[3]) tens = tens - 1;
    endtask

    // One clock cycle: drive, predict, compare at negedge, advance model after posedge.
    task automatic step(input logic s, input logic p);
        logic [5:0] e;
        start = s;
        pause = p;
        if (clr) model_reset();
        e = model_out();
        sb_q.push_back(e);
        @(negedge inter_clk);
        obs = {ld, cnt_ones, cnt_tens, running, expired, expire_pulse};
        if (sb_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else chk($sformatf("cyc%0d", cyc), obs, sb_q.pop_front());
        @(posedge inter_clk);
        model_advance(e);
        #1;
        tc_ones = (ones == 0);
        tc_tens = (tens == 0);
        cyc++;
    endtask

    initial begin
        int k, j, cnt_seen, pulses;
        logic found;
        n_cmp = 0; n_err = 0; cyc = 0;
        clr = 1'b1; start = 1'b0; pause = 1'b0;
        ones = 0; tens = 0; pre_ones = 2; pre_tens = 0;
        tc_ones = 1'b1; tc_tens = 1'b1;
        model_reset();
        @(posedge inter_clk); #1;

        // 1: reset holds everything low, then idle without ld
        for (int i = 0; i < 4; i++) begin
            step(i % 2 == 0, i % 3 == 0);
            chk("rst_out", obs, 6'd0);
        end
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("idle_no_ld", obs[5], 1'b0);
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(i % 2 == 0, i % 2 == 1);
            chk("rst_mid", obs, 6'd0);
        end
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            chk("rst_release", obs, 6'd0);
        end

        // 2: normal round from preset 02
        pre_tens = 0; pre_ones = 2;
        for (int i = 0; i <= 16; i++) begin
            step(i == 0, 1'b0);
            log_v[i] = obs;
        end
        chk("t2_ld1", log_v[1][5], 1'b1);
        chk("t2_ld2", log_v[2][5], 1'b0);
        chk("t2_cnt5", log_v[5][4:3], 2'b10);
        chk("t2_cnt9", log_v[9][4:3], 2'b10);
        chk("t2_nocnt13", log_v[13][4:3], 2'b00);
        chk("t2_exp14", log_v[14][1:0], 2'b11);
        chk("t2_exp15", log_v[15][1:0], 2'b10);
        chk("t2_exp16", log_v[16][1:0], 2'b10);

        // 3: borrow from preset 10
        pre_tens = 1; pre_ones = 0;
        step(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0);
            if (obs[4]) found = 1'b1;
        end
        chk("t3_found", found, 1'b1);
        chk("t3_borrow", obs[3], 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        chk("t3_expired", obs[1], 1'b1);

        // 4: pause with prescaler at 2 keeps the partial tick
        pre_tens = 0; pre_ones = 2;
        step(1'b1, 1'b0);
        for (int i = 0; i < 10 && !(m_st == M_RUN && m_psc == 2); i++) step(1'b0, 1'b0);
        chk("t4_psc2", m_psc, 32'd2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            chk("t4_running", obs[2], 1'b1);
            chk("t4_nocnt", obs[4:3], 2'b00);
        end
        k = -1;
        for (int i = 0; i < 8 && k < 0; i++) begin
            step(1'b0, 1'b0);
            if (obs[4]) k = i;
        end
        chk("t4_tick_delay", k, 32'd2);

        // 5: collisions
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("t5_ld_wins", obs[5], 1'b1);
        pre_tens = 0; pre_ones = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 10 && !obs[1]; i++) step(1'b0, 1'b0);
        chk("t5_expired", obs[1], 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_rearm_ld", obs[5], 1'b1);
        chk("t5_rearm_exp", obs[1], 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("t5_ld_pause", obs[5], 1'b1);
        step(1'b0, 1'b1);
        chk("t5_run_after_ld", obs[2], 1'b1);
        step(1'b0, 1'b1);
        chk("t5_paused", obs[2], 1'b1);

        // 6: zero preset expires on the first tick with no decrement
        step(1'b1, 1'b0);
        j = -1; cnt_seen = 0;
        for (int i = 0; i < 12 && j < 0; i++) begin
            step(1'b0, 1'b0);
            if (obs[4] | obs[3]) cnt_seen++;
            if (obs[0]) j = i;
        end
        chk("t6_pulse_at", j, 32'(DIV + 1));
        chk("t6_no_cnt", cnt_seen, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            if (obs[0]) pulses++;
        end
        chk("t6_no_repeat", pulses, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
